// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared constants for the CPU-to-cache request bridge
package mem_bridge_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RD_A  = 3'd1;
   localparam logic [2:0] ST_RD_D  = 3'd2;
   localparam logic [2:0] ST_WR_AW = 3'd3;
   localparam logic [2:0] ST_WR_B  = 3'd4;
   localparam logic [2:0] ST_RESP  = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   function automatic logic is_wait_state(input logic [2:0] st);
      return (st == ST_RD_A) || (st == ST_RD_D) || (st == ST_WR_AW) || (st == ST_WR_B);
   endfunction

endpackage

// File: rtl/wdt_counter.sv
// rtl/wdt_counter.sv - per-state watchdog; expired flags the last allowed wait cycle
module wdt_counter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Count starts at 0 on entry, so the TIMEOUT_CYCLES-th waiting cycle sees TIMEOUT_CYCLES-1.
   assign expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_req_bridge.sv
// rtl/mem_req_bridge.sv - single-outstanding CPU load/store to AXI4-Lite bridge with watchdog
module mem_req_bridge
   import mem_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int CNT_W          = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   output logic [31:0] m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic        err
);

   logic [2:0]  state;
   logic [2:0]  state_nx;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        arvalid_q;
   logic        rready_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        bready_q;
   logic        wdt_expired;
   logic        aw_done_nx;
   logic        w_done_nx;

   assign req_ready     = (state == ST_IDLE) && !rst;
   assign m_axi_araddr  = addr_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;

   // Each write channel is finished once its VALID is down or is being accepted this cycle.
   assign aw_done_nx = !awvalid_q || m_axi_awready;
   assign w_done_nx  = !wvalid_q || m_axi_wready;

   wdt_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_nx != state),
      .en      (is_wait_state(state)),
      .expired (wdt_expired)
   );

   // A handshake landing on the expiry cycle wins, so the slave never holds an orphaned beat.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_addr[1:0] != 2'b00) begin
                  state_nx = ST_RESP;
               end else if (req_we) begin
                  state_nx = ST_WR_AW;
               end else begin
                  state_nx = ST_RD_A;
               end
            end
         end
         ST_RD_A: begin
            if (m_axi_arready) begin
               state_nx = ST_RD_D;
            end else if (wdt_expired) begin
               state_nx = ST_RESP;
            end
         end
         ST_RD_D: begin
            if (m_axi_rvalid || wdt_expired) begin
               state_nx = ST_RESP;
            end
         end
         ST_WR_AW: begin
            if (aw_done_nx && w_done_nx) begin
               state_nx = ST_WR_B;
            end else if (wdt_expired) begin
               state_nx = ST_RESP;
            end
         end
         ST_WR_B: begin
            if (m_axi_bvalid || wdt_expired) begin
               state_nx = ST_RESP;
            end
         end
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_nx;
         resp_valid <= (state_nx == ST_RESP);
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  wstrb_q <= req_wstrb;
                  if (req_addr[1:0] != 2'b00) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (req_we) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     arvalid_q <= 1'b1;
                  end
               end
            end
            ST_RD_A: begin
               if (m_axi_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
               end else if (wdt_expired) begin
                  arvalid_q  <= 1'b0;
                  err        <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end
            end
            ST_RD_D: begin
               if (m_axi_rvalid) begin
                  rready_q   <= 1'b0;
                  resp_rdata <= m_axi_rdata;
                  resp_err   <= (m_axi_rresp != RESP_OKAY);
               end else if (wdt_expired) begin
                  rready_q   <= 1'b0;
                  err        <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end
            end
            ST_WR_AW: begin
               if (m_axi_awready) begin
                  awvalid_q <= 1'b0;
               end
               if (m_axi_wready) begin
                  wvalid_q <= 1'b0;
               end
               if (aw_done_nx && w_done_nx) begin
                  bready_q <= 1'b1;
               end else if (wdt_expired) begin
                  awvalid_q  <= 1'b0;
                  wvalid_q   <= 1'b0;
                  err        <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end
            end
            ST_WR_B: begin
               if (m_axi_bvalid) begin
                  bready_q   <= 1'b0;
                  resp_err   <= (m_axi_bresp != RESP_OKAY);
                  resp_rdata <= '0;
               end else if (wdt_expired) begin
                  bready_q   <= 1'b0;
                  err        <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
